nios2_timer_mem_checker: RTL and testbench



---
 rtl/nios2_timer_mem_checker.sv | 271 +++++++++++++++++++++++++++
 tb/tb_nios2_timer_mem_checker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_timer_mem_checker.sv
// -----------------------------------------------------------------------------
// nios2_timer_mem_checker
//
// Avalon-MM master that writes a generated pattern into a window of on-chip
// memory, reads the window back one word at a time and compares each word.
// It reports pass/fail, a saturating mismatch count and the first failing
// address. A run is started by a single-cycle start pulse while idle.
//
// Ports
//   clk, reset_n        sole clock, asynchronous active-low reset
//   start               begin a run (sampled only in IDLE)
//   base, length        window start word address and word count
//                       (length is clamped to DEPTH)
//   seed, pattern_sel   pattern(i) = seed (sel=0) or seed + i (sel=1)
//   busy, done          run in progress / one-cycle end-of-run pulse
//   pass, err_count,    results of the last run, held until the next start
//   first_err_addr
//   m_*                 Avalon-MM master port (word addressed, 32-bit)
//
// State table
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start, results held
//   S_WRITE | write strobe for word r_idx, held while waitrequest
//   S_READ  | read strobe for word r_idx, held while waitrequest
//   S_RDATA | read data for word r_idx present; compare and advance
//   S_DONE  | done pulse, results valid, back to idle
// -----------------------------------------------------------------------------
module nios2_timer_mem_checker #(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 10000,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] length,
   input  logic [DATA_W-1:0] seed,
   input  logic              pattern_sel,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [ADDR_W-1:0] m_address,
   output logic              m_write,
   output logic [DATA_W-1:0] m_writedata,
   output logic [3:0]        m_byteenable,
   output logic              m_read,
   input  logic [DATA_W-1:0] m_readdata,
   input  logic              m_waitrequest
);

   localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_RDATA,
      S_DONE
   } state_t;

   // base < DEPTH and i < DEPTH, so one conditional subtract is enough;
   // the sum is carried one bit wider so it cannot overflow before the wrap.
   function automatic logic [ADDR_W-1:0] f_addr(input logic [ADDR_W-1:0] b,
                                                input logic [ADDR_W-1:0] i);
      logic [ADDR_W:0] sum;
      sum = {1'b0, b} + {1'b0, i};
      if (sum >= L_DEPTH)
         sum = sum - L_DEPTH;
      return ADDR_W'(sum);
   endfunction

   function automatic logic [DATA_W-1:0] f_pat(input logic [DATA_W-1:0] s,
                                               input logic              sel,
                                               input logic [ADDR_W-1:0] i);
      return sel ? (s + DATA_W'(i)) : s;
   endfunction

   state_t              r_state, w_nxt_state;
   logic [ADDR_W-1:0]   r_base, w_nxt_base;
   logic [ADDR_W-1:0]   r_len, w_nxt_len;
   logic [DATA_W-1:0]   r_seed, w_nxt_seed;
   logic                r_psel, w_nxt_psel;
   logic [ADDR_W-1:0]   r_idx, w_nxt_idx;

   logic                r_busy, w_nxt_busy;
   logic                r_done, w_nxt_done;
   logic                r_pass, w_nxt_pass;
   logic [15:0]         r_err_cnt, w_nxt_err_cnt;
   logic [ADDR_W-1:0]   r_first_err, w_nxt_first_err;
   logic [ADDR_W-1:0]   r_m_addr, w_nxt_m_addr;
   logic                r_m_write, w_nxt_m_write;
   logic [DATA_W-1:0]   r_m_wdata, w_nxt_m_wdata;
   logic [3:0]          r_m_be, w_nxt_m_be;
   logic                r_m_read, w_nxt_m_read;

   logic [ADDR_W-1:0]   w_len_clamp;
   logic [ADDR_W-1:0]   w_idx_inc;
   logic [ADDR_W-1:0]   w_addr_cur;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic [DATA_W-1:0]   w_pat_cur;
   logic [DATA_W-1:0]   w_pat_nxt;
   logic                w_last;

   assign w_len_clamp = ({1'b0, length} > L_DEPTH) ? ADDR_W'(L_DEPTH) : length;
   assign w_idx_inc   = r_idx + ADDR_W'(1);
   assign w_addr_cur  = f_addr(r_base, r_idx);
   assign w_addr_nxt  = f_addr(r_base, w_idx_inc);
   assign w_pat_cur   = f_pat(r_seed, r_psel, r_idx);
   assign w_pat_nxt   = f_pat(r_seed, r_psel, w_idx_inc);
   // Only evaluated in WRITE/RDATA, where r_len is at least 1.
   assign w_last      = (r_idx == (r_len - ADDR_W'(1)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_base      <= '0;
         r_len       <= '0;
         r_seed      <= '0;
         r_psel      <= 1'b0;
         r_idx       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_err_cnt   <= '0;
         r_first_err <= '0;
         r_m_addr    <= '0;
         r_m_write   <= 1'b0;
         r_m_wdata   <= '0;
         r_m_be      <= '0;
         r_m_read    <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_base      <= w_nxt_base;
         r_len       <= w_nxt_len;
         r_seed      <= w_nxt_seed;
         r_psel      <= w_nxt_psel;
         r_idx       <= w_nxt_idx;
         r_busy      <= w_nxt_busy;
         r_done      <= w_nxt_done;
         r_pass      <= w_nxt_pass;
         r_err_cnt   <= w_nxt_err_cnt;
         r_first_err <= w_nxt_first_err;
         r_m_addr    <= w_nxt_m_addr;
         r_m_write   <= w_nxt_m_write;
         r_m_wdata   <= w_nxt_m_wdata;
         r_m_be      <= w_nxt_m_be;
         r_m_read    <= w_nxt_m_read;
      end
   end

   // Next-state and next-output logic. Every output is registered, so the
   // values computed here are what the bus sees in the following cycle.
   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_base      = r_base;
      w_nxt_len       = r_len;
      w_nxt_seed      = r_seed;
      w_nxt_psel      = r_psel;
      w_nxt_idx       = r_idx;
      w_nxt_busy      = r_busy;
      w_nxt_done      = 1'b0;
      w_nxt_pass      = r_pass;
      w_nxt_err_cnt   = r_err_cnt;
      w_nxt_first_err = r_first_err;
      w_nxt_m_addr    = r_m_addr;
      w_nxt_m_write   = r_m_write;
      w_nxt_m_wdata   = r_m_wdata;
      w_nxt_m_be      = r_m_be;
      w_nxt_m_read    = r_m_read;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_nxt_base      = base;
               w_nxt_len       = w_len_clamp;
               w_nxt_seed      = seed;
               w_nxt_psel      = pattern_sel;
               w_nxt_idx       = '0;
               w_nxt_err_cnt   = '0;
               w_nxt_first_err = '0;
               w_nxt_pass      = 1'b0;
               if (w_len_clamp == '0) begin
                  w_nxt_state = S_DONE;
                  w_nxt_done  = 1'b1;
                  w_nxt_pass  = 1'b1;
               end else begin
                  // pattern(0) is seed for either pattern type
                  w_nxt_state   = S_WRITE;
                  w_nxt_busy    = 1'b1;
                  w_nxt_m_write = 1'b1;
                  w_nxt_m_addr  = base;
                  w_nxt_m_wdata = seed;
                  w_nxt_m_be    = 4'hF;
               end
            end
         end

         S_WRITE: begin
            if (!m_waitrequest) begin
               if (w_last) begin
                  w_nxt_state   = S_READ;
                  w_nxt_idx     = '0;
                  w_nxt_m_write = 1'b0;
                  w_nxt_m_read  = 1'b1;
                  w_nxt_m_addr  = r_base;
               end else begin
                  w_nxt_idx     = w_idx_inc;
                  w_nxt_m_addr  = w_addr_nxt;
                  w_nxt_m_wdata = w_pat_nxt;
               end
            end
         end

         S_READ: begin
            if (!m_waitrequest) begin
               w_nxt_state  = S_RDATA;
               w_nxt_m_read = 1'b0;
               w_nxt_m_be   = 4'h0;
            end
         end

         S_RDATA: begin
            if (m_readdata != w_pat_cur) begin
               if (r_err_cnt != 16'hFFFF)
                  w_nxt_err_cnt = r_err_cnt + 16'd1;
               // err_count never returns to zero within a run, so zero
               // marks the first mismatch even after saturation.
               if (r_err_cnt == 16'd0)
                  w_nxt_first_err = w_addr_cur;
            end
            if (w_last) begin
               w_nxt_state = S_DONE;
               w_nxt_busy  = 1'b0;
               w_nxt_done  = 1'b1;
               w_nxt_pass  = (w_nxt_err_cnt == 16'd0);
            end else begin
               w_nxt_state  = S_READ;
               w_nxt_idx    = w_idx_inc;
               w_nxt_m_read = 1'b1;
               w_nxt_m_addr = w_addr_nxt;
               w_nxt_m_be   = 4'hF;
            end
         end

         S_DONE: begin
            w_nxt_state = S_IDLE;
         end

         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_busy  = 1'b0;
         end
      endcase
   end

   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign err_count      = r_err_cnt;
   assign first_err_addr = r_first_err;
   assign m_address      = r_m_addr;
   assign m_write        = r_m_write;
   assign m_writedata    = r_m_wdata;
   assign m_byteenable   = r_m_be;
   assign m_read         = r_m_read;

endmodule

// File: tb/tb_nios2_timer_mem_checker.sv
module tb_nios2_timer_mem_checker;

   localparam int ADDR_W = 14;
   localparam int DEPTH  = 10000;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base = '0;
   logic [ADDR_W-1:0] length = '0;
   logic [DATA_W-1:0] seed = '0;
   logic              pattern_sel = 1'b0;
   logic              busy, done, pass;
   logic [15:0]       err_count;
   logic [ADDR_W-1:0] first_err_addr;
   logic [ADDR_W-1:0] m_address;
   logic              m_write, m_read;
   logic [DATA_W-1:0] m_writedata;
   logic [3:0]        m_byteenable;
   logic [DATA_W-1:0] m_readdata = '0;
   logic              m_waitrequest;

   int checks = 0;
   int errors = 0;

   // memory / bus model state
   logic [DATA_W-1:0] mem [0:DEPTH-1];
   int n_wr = 0, n_rd = 0, n_strobe = 0, n_stall = 0, stab_viol = 0;
   int wst = 0, rdst = 0;
   int stall_n = 0;
   int fault_addr = -1;
   logic [ADDR_W-1:0] wr_addr [0:15];
   logic [DATA_W-1:0] wr_data [0:15];
   logic [ADDR_W-1:0] rd_addr [0:15];
   logic              prev_stall = 1'b0;
   logic [ADDR_W-1:0] p_addr = '0;
   logic [DATA_W-1:0] p_wdata = '0;
   logic              p_w = 1'b0, p_r = 1'b0;
   logic [3:0]        p_be = '0;

   always #5 clk = ~clk;

   nios2_timer_mem_checker #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base(base), .length(length),
      .seed(seed), .pattern_sel(pattern_sel), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_addr(first_err_addr), .m_address(m_address),
      .m_write(m_write), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
      .m_read(m_read), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
   );

   // Stall only the first write and first read of a run, stall_n cycles each.
   assign m_waitrequest = (m_write && n_wr == 0 && wst < stall_n) ||
                          (m_read  && n_rd == 0 && rdst < stall_n);

   always @(posedge clk) begin
      if (start && !busy) begin
         n_wr <= 0; n_rd <= 0; n_strobe <= 0; n_stall <= 0;
         wst <= 0; rdst <= 0; stab_viol <= 0; prev_stall <= 1'b0;
      end else begin
         if (m_write || m_read) n_strobe <= n_strobe + 1;
         if (m_waitrequest) begin
            n_stall <= n_stall + 1;
            if (m_write) wst <= wst + 1;
            if (m_read) rdst <= rdst + 1;
         end
         if (m_write && !m_waitrequest) begin
            if (int'(m_address) < DEPTH) mem[m_address] <= m_writedata;
            if (n_wr < 16) begin
               wr_addr[n_wr] <= m_address;
               wr_data[n_wr] <= m_writedata;
            end
            n_wr <= n_wr + 1;
         end
         if (m_read && !m_waitrequest) begin
            m_readdata <= mem[m_address] ^ ((int'(m_address) == fault_addr) ? 32'd1 : 32'd0);
            if (n_rd < 16) rd_addr[n_rd] <= m_address;
            n_rd <= n_rd + 1;
         end
         if (prev_stall && (m_address != p_addr || m_writedata != p_wdata ||
                            m_write != p_w || m_read != p_r || m_byteenable != p_be))
            stab_viol <= stab_viol + 1;
         prev_stall <= m_waitrequest;
         p_addr <= m_address; p_wdata <= m_writedata;
         p_w <= m_write; p_r <= m_read; p_be <= m_byteenable;
      end
   end

   // Start a run at the next edge (edge k); cyc counts cycles after edge k
   // until done is seen. glitch>0 pulses start (with other parameters) at
   // that cycle to check it is ignored while busy.
   task automatic do_run(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l,
                         input logic [DATA_W-1:0] s, input logic p, input int glitch,
                         input int budget, output int cyc, output logic busy1,
                         output logic busy_at_done);
      base = b; length = l; seed = s; pattern_sel = p; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      busy1 = busy;
      while (done !== 1'b1 && cyc < budget) begin
         if (cyc == glitch) begin
            base = 14'd100; length = 14'd1; seed = 32'hFF; pattern_sel = 1'b0; start = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      busy_at_done = busy;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #12;
      checks++;
      if ({busy, done, pass, err_count, first_err_addr} !== '0) begin
         errors++;
         $display("FAIL reset_status: got busy=%b done=%b pass=%b err=%0d first=%0d required all 0",
                  busy, done, pass, err_count, first_err_addr);
      end
      checks++;
      if ({m_write, m_read, m_byteenable, m_address, m_writedata} !== '0) begin
         errors++;
         $display("FAIL reset_bus: got w=%b r=%b be=%h a=%0d d=%h required all 0",
                  m_write, m_read, m_byteenable, m_address, m_writedata);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      // start a run and reset it in the middle of the write phase
      base = 14'd50; length = 14'd4; seed = 32'h1234; pattern_sel = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (m_write !== 1'b1 || m_address !== 14'd51 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_midwrite_pre: got w=%b a=%0d busy=%b required w=1 a=51 busy=1",
                  m_write, m_address, busy);
      end
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, m_write, m_read, m_byteenable, m_address, m_writedata} !== '0) begin
         errors++;
         $display("FAIL reset_async: got busy=%b w=%b r=%b be=%h a=%0d d=%h required all 0",
                  busy, m_write, m_read, m_byteenable, m_address, m_writedata);
      end
      #2;
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || m_write !== 1'b0 || m_read !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b w=%b r=%b done=%b required 0 0 0 0",
                  busy, m_write, m_read, done);
      end
   endtask

   task automatic test_const_fill();
      int cyc; logic b1, bd;
      do_run(14'd0, 14'd4, 32'hA5A5A5A5, 1'b0, 0, 100, cyc, b1, bd);
      checks++;
      if (cyc != 13 || b1 !== 1'b1 || bd !== 1'b0) begin
         errors++;
         $display("FAIL const_timing: got done@%0d busy1=%b busy_done=%b required 13 1 0", cyc, b1, bd);
      end
      checks++;
      if (n_wr != 4 || n_rd != 4) begin
         errors++;
         $display("FAIL const_counts: got wr=%0d rd=%0d required 4 4", n_wr, n_rd);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wr_addr[i] !== 14'(i) || wr_data[i] !== 32'hA5A5A5A5 || rd_addr[i] !== 14'(i)) begin
            errors++;
            $display("FAIL const_word%0d: got wa=%0d wd=%h ra=%0d required %0d a5a5a5a5 %0d",
                     i, wr_addr[i], wr_data[i], rd_addr[i], i, i);
         end
      end
      checks++;
      if (pass !== 1'b1 || err_count !== 16'd0 || first_err_addr !== 14'd0) begin
         errors++;
         $display("FAIL const_result: got pass=%b err=%0d first=%0d required 1 0 0",
                  pass, err_count, first_err_addr);
      end
   endtask

   task automatic test_wrap_incr();
      int cyc; logic b1, bd;
      logic [ADDR_W-1:0] exp_a [0:3];
      exp_a[0] = 14'd9998; exp_a[1] = 14'd9999; exp_a[2] = 14'd0; exp_a[3] = 14'd1;
      do_run(14'd9998, 14'd4, 32'h100, 1'b1, 0, 100, cyc, b1, bd);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wr_addr[i] !== exp_a[i] || wr_data[i] !== 32'h100 + 32'(i) || rd_addr[i] !== exp_a[i]) begin
            errors++;
            $display("FAIL wrap_word%0d: got wa=%0d wd=%h ra=%0d required %0d %h %0d",
                     i, wr_addr[i], wr_data[i], rd_addr[i], exp_a[i], 32'h100 + 32'(i), exp_a[i]);
         end
      end
      checks++;
      if (pass !== 1'b1 || err_count !== 16'd0 || cyc != 13) begin
         errors++;
         $display("FAIL wrap_result: got pass=%b err=%0d done@%0d required 1 0 13", pass, err_count, cyc);
      end
   endtask

   task automatic test_err_inject();
      int cyc; logic b1, bd;
      fault_addr = 5;
      do_run(14'd3, 14'd8, 32'h0, 1'b0, 0, 100, cyc, b1, bd);
      fault_addr = -1;
      checks++;
      if (err_count !== 16'd1 || first_err_addr !== 14'd5 || pass !== 1'b0) begin
         errors++;
         $display("FAIL err_inject: got err=%0d first=%0d pass=%b required 1 5 0",
                  err_count, first_err_addr, pass);
      end
      checks++;
      if (cyc != 25) begin
         errors++;
         $display("FAIL err_timing: got done@%0d required 25", cyc);
      end
      do_run(14'd3, 14'd8, 32'h0, 1'b0, 0, 100, cyc, b1, bd);
      checks++;
      if (err_count !== 16'd0 || first_err_addr !== 14'd0 || pass !== 1'b1) begin
         errors++;
         $display("FAIL err_clean_rerun: got err=%0d first=%0d pass=%b required 0 0 1",
                  err_count, first_err_addr, pass);
      end
   endtask

   task automatic test_stalls();
      int cyc; logic b1, bd;
      stall_n = 3;
      do_run(14'd10, 14'd2, 32'hDEADBEEF, 1'b1, 0, 100, cyc, b1, bd);
      stall_n = 0;
      checks++;
      if (cyc != 13) begin
         errors++;
         $display("FAIL stall_timing: got done@%0d required 13", cyc);
      end
      checks++;
      if (n_wr != 2 || n_rd != 2 || n_stall != 6) begin
         errors++;
         $display("FAIL stall_counts: got wr=%0d rd=%0d stalls=%0d required 2 2 6", n_wr, n_rd, n_stall);
      end
      checks++;
      if (stab_viol != 0) begin
         errors++;
         $display("FAIL stall_stable: got %0d changes under waitrequest required 0", stab_viol);
      end
      checks++;
      if (wr_addr[0] !== 14'd10 || wr_addr[1] !== 14'd11 ||
          wr_data[0] !== 32'hDEADBEEF || wr_data[1] !== 32'hDEADBEF0 || pass !== 1'b1) begin
         errors++;
         $display("FAIL stall_data: got a=%0d,%0d d=%h,%h pass=%b required 10,11 deadbeef,deadbef0 1",
                  wr_addr[0], wr_addr[1], wr_data[0], wr_data[1], pass);
      end
   endtask

   task automatic test_len_zero();
      int cyc; logic b1, bd;
      do_run(14'd7, 14'd0, 32'h55, 1'b0, 0, 50, cyc, b1, bd);
      checks++;
      if (cyc != 1 || b1 !== 1'b0 || pass !== 1'b1 || n_strobe != 0) begin
         errors++;
         $display("FAIL len_zero: got done@%0d busy=%b pass=%b strobes=%0d required 1 0 1 0",
                  cyc, b1, pass, n_strobe);
      end
   endtask

   task automatic test_start_while_busy();
      int cyc; logic b1, bd;
      do_run(14'd20, 14'd4, 32'h7, 1'b1, 3, 100, cyc, b1, bd);
      checks++;
      if (cyc != 13 || n_wr != 4 || n_rd != 4 || pass !== 1'b1) begin
         errors++;
         $display("FAIL busy_start: got done@%0d wr=%0d rd=%0d pass=%b required 13 4 4 1",
                  cyc, n_wr, n_rd, pass);
      end
      checks++;
      if (wr_addr[3] !== 14'd23 || wr_data[3] !== 32'hA) begin
         errors++;
         $display("FAIL busy_start_data: got a=%0d d=%h required 23 0000000a", wr_addr[3], wr_data[3]);
      end
   endtask

   task automatic test_clamp();
      int cyc; logic b1, bd;
      do_run(14'd0, 14'd12000, 32'h0, 1'b1, 0, 30100, cyc, b1, bd);
      checks++;
      if (n_wr != 10000 || n_rd != 10000) begin
         errors++;
         $display("FAIL clamp_counts: got wr=%0d rd=%0d required 10000 10000", n_wr, n_rd);
      end
      checks++;
      if (cyc != 30001 || pass !== 1'b1 || err_count !== 16'd0) begin
         errors++;
         $display("FAIL clamp_result: got done@%0d pass=%b err=%0d required 30001 1 0",
                  cyc, pass, err_count);
      end
   endtask

   initial begin
      test_reset();
      test_const_fill();
      test_wrap_incr();
      test_err_inject();
      test_stalls();
      test_len_zero();
      test_start_while_busy();
      test_clamp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
